scale_mux_rr: RTL and testbench
===============================

Name: scale_mux_rr

Overview:
- Parametrised successor to the single-bit 2:1 scale mux.
- N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Selection is by an internal arbiter (round-robin or fixed-priority) instead of an external select line.
- Sits between multiple producer channels and one shared consumer.
- One-deep output register gives one cycle of latency and full throughput.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1)
- CHANNELS, 4, number of input channels (2..16)
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins

Ports:
- clk  input  1  single clock, rising edge
- rst_  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS x WIDTH (unpacked array of logic [WIDTH-1:0])  per-channel data
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- out_data  output  WIDTH  registered selected data
- out_chan  output  CHAN_W = $clog2(CHANNELS)  index of the channel that sourced out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready

Behaviour:
- Reset (rst_ low, asynchronous): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, lock state=IDLE.
  - in_ready is all-zero while rst_ is low.
- Transfer rule: a beat moves on any interface when valid && ready at a rising clk edge.
- load_en = !out_valid || out_ready, combinational.
  - The output register accepts a new beat whenever it is empty or is being drained in the same cycle.
- Grant, combinational one-hot among asserted in_valid bits:
  - RR_MODE=1: first valid channel searching upward from rr_ptr, wrapping CHANNELS-1 -> 0.
  - RR_MODE=0: lowest asserted index wins.
- in_ready[i] = load_en && grant[i]. At most one in_ready bit is high in any cycle.
- On a transfer from channel g: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - RR_MODE=1 only: rr_ptr <= (g+1) mod CHANNELS.
  - CHANNELS need not be a power of two; the wrap must be explicit.
- load_en high with no in_valid asserted: out_valid <= 0 (if it was draining); rr_ptr unchanged.
- Backpressure: out_valid=1 and out_ready=0 holds out_data, out_chan and out_valid stable, and all in_ready stay 0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- in_valid deasserted without a transfer: legal. Arbitration is re-evaluated every cycle when no lock is held.
- Reset mid-operation: the beat held in the output register is discarded. No partial state survives.

Optional Feature:
- Macro: SCALE_MUX_LOCK_EN
- Defined:
  - Adds port in_last (input, CHANNELS bits), marking the last beat of a packet.
  - Adds port out_last (output, 1 bit, registered with the data, reset 0).
  - Two-state FSM:
    - IDLE: on a transfer where in_last[g]=0, go to LOCKED, hold lock_chan=g.
    - LOCKED: grant is forced to lock_chan regardless of other valids.
    - LOCKED: on a transfer with in_last[lock_chan]=1, return to IDLE. rr_ptr advances only then.
  - A single-beat packet (in_last=1) stays in IDLE.
- Undefined: no in_last/out_last ports, no FSM. Every beat is arbitrated independently.

Decomposition:
- Package scale_mux_pkg holds:
  - the lock_state_e enum (IDLE, LOCKED);
  - function chan_w(int n), which returns $clog2(n) with a minimum of 1;
  - function rr_next(ptr, n), the wrap-around increment.
- Sub-module scale_mux_arb (CHANNELS, RR_MODE): inputs are the req vector, rr_ptr, lock and lock_chan; outputs are the one-hot grant and its encoded index. Purely combinational.
- Top level holds the output register, rr_ptr and the lock FSM.

Test Plan:
- Reset: assert rst_ low mid-cycle with out_valid=1 -> out_valid, out_data, out_chan all 0 immediately, without waiting for a clk edge; in_ready=0.
- Round-robin (RR_MODE=1, CHANNELS=4, WIDTH=8):
  - All four channels valid with data 0x10, 0x20, 0x30, 0x40 and out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0 on consecutive cycles; out_data 0x10, 0x20, 0x30, 0x40, 0x10.
- Fixed priority (RR_MODE=0): channels 1 and 3 valid continuously -> channel 1 granted every cycle; in_ready[3] never high.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 and out_data=0x5A -> out_data stays 0x5A; all in_ready=0; accepted on the 4th cycle when out_ready=1.
- Wrap with CHANNELS=3 (non-power-of-2):
  - Only channel 2 is valid, then channels 0 and 2 are valid.
  - Required: after the grant to channel 2, rr_ptr=0, so channel 0 wins next.
- SCALE_MUX_LOCK_EN:
  - Channel 0 sends 3 beats with in_last=0,0,1 while channel 1 is valid throughout.
  - Required: out_chan=0 for 3 beats with out_last=0,0,1, then out_chan=1.

Source files
------------

// File: rtl/scale_mux_pkg.sv
// scale_mux shared types and helpers.
// Lock state is only used when SCALE_MUX_LOCK_EN is defined.
package scale_mux_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_e;

  function automatic int chan_w(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(int ptr, int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/scale_mux_arb.sv
// scale_mux channel arbiter: round-robin or fixed priority.
// Purely combinational; a held lock overrides the search.
module scale_mux_arb
  import scale_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  parameter int CW       = chan_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CW-1:0]       rr_ptr,
  input  logic                lock,
  input  logic [CW-1:0]       lock_chan,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       grant_idx
);

  int          pos;
  logic [CW-1:0] idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    idx       = '0;
    if (lock) begin
      grant[lock_chan] = req[lock_chan];
      grant_idx        = lock_chan;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // search starts at rr_ptr and wraps explicitly
        pos = (RR_MODE != 0) ? int'(rr_ptr) + k : k;
        if (pos >= CHANNELS) pos = pos - CHANNELS;
        idx = CW'(pos);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = idx;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/scale_mux_rr.sv
// N-channel registered mux with arbitrated valid/ready inputs.
// Packet lock with in_last/out_last when SCALE_MUX_LOCK_EN is defined.
module scale_mux_rr
  import scale_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int RR_MODE  = 1,
  localparam int CHAN_W  = chan_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [WIDTH-1:0]    in_data [CHANNELS],
  input  logic [CHANNELS-1:0] in_valid,
`ifdef SCALE_MUX_LOCK_EN
  input  logic [CHANNELS-1:0] in_last,
`endif
  output logic [CHANNELS-1:0] in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CHAN_W-1:0]   out_chan,
  output logic                out_valid,
`ifdef SCALE_MUX_LOCK_EN
  output logic                out_last,
`endif
  input  logic                out_ready
);

  logic                load_en;
  logic                xfer;
  logic                adv;
  logic                lock;
  logic [CHANNELS-1:0] grant;
  logic [CHAN_W-1:0]   gidx;
  logic [CHAN_W-1:0]   rr_ptr;
  logic [CHAN_W-1:0]   lock_chan;

  scale_mux_arb #(
    .CHANNELS (CHANNELS),
    .RR_MODE  (RR_MODE),
    .CW       (CHAN_W)
  ) u_arb (
    .req       (in_valid),
    .rr_ptr    (rr_ptr),
    .lock      (lock),
    .lock_chan (lock_chan),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (rst_ && load_en) ? grant : '0;
  assign xfer     = |in_ready;

`ifdef SCALE_MUX_LOCK_EN
  lock_state_e state;

  assign lock = (state == LOCKED);
  // pointer moves only once a packet has finished
  assign adv  = in_last[gidx];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      lock_chan <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_last <= in_last[gidx];
      if (in_last[gidx]) begin
        state <= IDLE;
      end else begin
        state     <= LOCKED;
        lock_chan <= gidx;
      end
    end
  end
`else
  assign lock      = 1'b0;
  assign lock_chan = '0;
  assign adv       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx];
        out_chan <= gidx;
        if (RR_MODE != 0 && adv)
          rr_ptr <= CHAN_W'(rr_next(int'(gidx), CHANNELS));
      end
    end
  end

endmodule

// File: tb/tb_scale_mux_rr.sv
// Scoreboard bench for scale_mux_rr: RR 4ch, fixed 4ch, RR 3ch.
// Reference model arbitrates from the rules; monitor pops per beat.
module tb_scale_mux_rr;

`ifdef SCALE_MUX_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct {
    int         chan;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic [7:0] in_data [4];
  logic [7:0] d3 [3];
  logic [3:0] in_valid = '0;
  logic [3:0] in_last = '1;
  logic       out_ready = 1'b0;

  logic [3:0] rdy [3];
  logic [2:0] rdy3;
  logic [7:0] od [3];
  logic [1:0] oc [3];
  logic       ov [3];
  logic       ol [3];

  exp_t q0[$], q1[$], q2[$];
  int   total = 0;
  int   bad = 0;

  int nch [3] = '{4, 4, 3};
  int rrm [3] = '{1, 0, 1};
  int ptr [3] = '{0, 0, 0};
  bit full [3] = '{0, 0, 0};
  bit lk [3] = '{0, 0, 0};
  int lkc [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  assign d3[0] = in_data[0];
  assign d3[1] = in_data[1];
  assign d3[2] = in_data[2];
  assign rdy[2] = {1'b0, rdy3};

  scale_mux_rr #(.WIDTH(8), .CHANNELS(4), .RR_MODE(1)) dut (
    .clk(clk), .rst_(rst_), .in_data(in_data),
    .in_valid(in_valid),
`ifdef SCALE_MUX_LOCK_EN
    .in_last(in_last), .out_last(ol[0]),
`endif
    .in_ready(rdy[0]), .out_data(od[0]), .out_chan(oc[0]),
    .out_valid(ov[0]), .out_ready(out_ready)
  );

  scale_mux_rr #(.WIDTH(8), .CHANNELS(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_(rst_), .in_data(in_data),
    .in_valid(in_valid),
`ifdef SCALE_MUX_LOCK_EN
    .in_last(in_last), .out_last(ol[1]),
`endif
    .in_ready(rdy[1]), .out_data(od[1]), .out_chan(oc[1]),
    .out_valid(ov[1]), .out_ready(out_ready)
  );

  scale_mux_rr #(.WIDTH(8), .CHANNELS(3), .RR_MODE(1)) dut3 (
    .clk(clk), .rst_(rst_), .in_data(d3),
    .in_valid(in_valid[2:0]),
`ifdef SCALE_MUX_LOCK_EN
    .in_last(in_last[2:0]), .out_last(ol[2]),
`endif
    .in_ready(rdy3), .out_data(od[2]), .out_chan(oc[2]),
    .out_valid(ov[2]), .out_ready(out_ready)
  );

`ifndef SCALE_MUX_LOCK_EN
  assign ol[0] = 1'b0;
  assign ol[1] = 1'b0;
  assign ol[2] = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int qsize(int m);
    case (m)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(int m);
    case (m)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(int m, exp_t e);
    case (m)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Reference: decide the grant for the coming edge from spec rules.
  task automatic model_step();
    int   n, g, c;
    bit   ld;
    logic [3:0] er;
    exp_t e;
    for (int m = 0; m < 3; m++) begin
      n  = nch[m];
      g  = -1;
      ld = !full[m] || out_ready;
      if (lk[m]) begin
        if (in_valid[lkc[m]]) g = lkc[m];
      end else begin
        for (int k = 0; k < n; k++) begin
          c = (rrm[m] != 0) ? (ptr[m] + k) % n : k;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
      er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
      chk($sformatf("ready%0d", m), int'(rdy[m]), int'(er));
      if (ld) begin
        full[m] = (g >= 0);
        if (g >= 0) begin
          e.chan = g;
          e.data = in_data[g];
          e.last = LOCK && in_last[g];
          qpush(m, e);
          if (LOCK && !in_last[g]) begin
            lk[m]  = 1'b1;
            lkc[m] = g;
          end else begin
            lk[m]  = 1'b0;
            ptr[m] = (g + 1) % n;
          end
        end
      end
    end
  endtask

  task automatic mon(input int m);
    exp_t e;
    chk($sformatf("valid%0d", m), int'(ov[m]), int'(full[m]));
    if (ov[m] && out_ready) begin
      if (qsize(m) == 0) begin
        total++;
        bad++;
        $display("FAIL beat%0d: got chan %0d, nothing expected",
                 m, oc[m]);
      end else begin
        e = qpop(m);
        chk($sformatf("chan%0d", m), int'(oc[m]), e.chan);
        chk($sformatf("data%0d", m), int'(od[m]), int'(e.data));
        chk($sformatf("last%0d", m), int'(ol[m]), int'(e.last));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_) begin
      for (int m = 0; m < 3; m++) mon(m);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_valid%0d", m), int'(ov[m]), 0);
      chk($sformatf("rst_data%0d", m), int'(od[m]), 0);
      chk($sformatf("rst_chan%0d", m), int'(oc[m]), 0);
      chk($sformatf("rst_ready%0d", m), int'(rdy[m]), 0);
      full[m] = 1'b0;
      ptr[m]  = 0;
      lk[m]   = 1'b0;
      lkc[m]  = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  int         exp_c [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_d [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

  initial begin
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    #1;
    do_reset();

    // round-robin order with all channels requesting
    in_data[0] = 8'h10; in_data[1] = 8'h20;
    in_data[2] = 8'h30; in_data[3] = 8'h40;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("rr_chan[%0d]", k), int'(oc[0]), exp_c[k]);
      chk($sformatf("rr_data[%0d]", k), int'(od[0]), int'(exp_d[k]));
    end

    // fixed priority: channel 1 always beats channel 3
    in_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("fp_ready", int'(rdy[1]), 4'b0010);
      chk("fp_chan", int'(oc[1]), 1);
    end

    // backpressure holds 0x5A for three cycles
    in_data[0] = 8'h5A;
    in_data[1] = 8'h21;
    in_valid = 4'b0001;
    cyc();
    chk("bp_load", int'(od[0]), 8'h5A);
    out_ready = 1'b0;
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_hold", int'(od[0]), 8'h5A);
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_ready", int'(rdy[0]), 0);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_next_chan", int'(oc[0]), 1);
    chk("bp_next_data", int'(od[0]), 8'h21);

    // async reset while a beat is held and inputs request
    chk("pre_rst_valid", int'(ov[0]), 1);
    do_reset();

    // 3-channel wrap: after channel 2 the pointer is back at 0
    in_valid = 4'b0100;
    cyc();
    chk("wrap_first", int'(oc[2]), 2);
    in_valid = 4'b0101;
    cyc();
    chk("wrap_second", int'(oc[2]), 0);

    if (LOCK) begin
      do_reset();
      in_valid = 4'b0011;
      for (int k = 0; k < 3; k++) begin
        in_data[0] = 8'hA0 + 8'(k);
        in_last = (k == 2) ? 4'b1111 : 4'b1110;
        cyc();
        chk($sformatf("lock_chan[%0d]", k), int'(oc[0]), 0);
        chk($sformatf("lock_last[%0d]", k), int'(ol[0]),
            (k == 2) ? 1 : 0);
      end
      in_valid = 4'b0010;
      in_last = 4'b1111;
      cyc();
      chk("lock_after", int'(oc[0]), 1);
    end

    // random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      in_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_last = LOCK ? 4'($urandom) : 4'b1111;
      cyc();
    end

    in_valid = 4'b0000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("drain_q%0d", m), qsize(m), 0);
      chk($sformatf("drain_valid%0d", m), int'(ov[m]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
